// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: redirect flush, load-use stall, CSR-write drain and operand forwarding.
// Optional HAZARD_PERF_EN adds free-running stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned CSR_DRAIN_CYC = 2,
  parameter int unsigned XLEN_PC       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_id,
  input  logic [4:0]         rs1_id,
  input  logic [4:0]         rs2_id,
  input  logic               uses_rs1,
  input  logic               uses_rs2,
  input  logic [4:0]         rd_ex,
  input  logic               rf_enb1,
  input  logic               is_Iload_typeb1,
  input  logic               is_JALb1,
  input  logic               is_JALRb1,
  input  logic               is_mretb1,
  input  logic               csr_wrb1,
  input  logic               br_taken_ex,
  input  logic [XLEN_PC-1:0] target_ex,
  input  logic [4:0]         rd_mem,
  input  logic [4:0]         rd_wb,
  input  logic               rf_en_mem,
  input  logic               rf_en_wb,
  output logic               stall_if,
  output logic               stall_id,
  output logic               flush_if_id,
  output logic               flush_id_ex,
  output logic               pc_redirect,
  output logic [XLEN_PC-1:0] pc_target,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_count
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    S_IDLE,
    S_CSR_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             redirect;
  logic             load_use;

  assign redirect = br_taken_ex | is_JALb1 | is_JALRb1 | is_mretb1;
  assign load_use = valid_id & is_Iload_typeb1 & rf_enb1 & (rd_ex != 5'd0) &
                    ((uses_rs1 & (rs1_id == rd_ex)) | (uses_rs2 & (rs2_id == rd_ex)));

  // Next-state and control outputs; all outputs forced low while reset is held.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;

    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          pc_redirect = 1'b1;
          pc_target   = target_ex;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else begin
          if (load_use) begin
            stall_if    = 1'b1;
            stall_id    = 1'b1;
            flush_id_ex = 1'b1;
          end
          if (csr_wrb1) begin
            state_d = S_CSR_DRAIN;
            cnt_d   = CNT_W'(CSR_DRAIN_CYC);
          end
        end
      end
      S_CSR_DRAIN: begin
        // EX carries bubbles here, so redirect and load-use cannot be live.
        stall_if    = 1'b1;
        stall_id    = 1'b1;
        flush_id_ex = 1'b1;
        cnt_d       = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (rf_en_mem && (rd_mem != 5'd0) && (rd_mem == rs1_id)) begin
      fwd_a = FWD_MEM;
    end else if (rf_en_wb && (rd_wb != 5'd0) && (rd_wb == rs1_id)) begin
      fwd_a = FWD_WB;
    end

    if (rf_en_mem && (rd_mem != 5'd0) && (rd_mem == rs2_id)) begin
      fwd_b = FWD_MEM;
    end else if (rf_en_wb && (rd_wb != 5'd0) && (rd_wb == rs2_id)) begin
      fwd_b = FWD_WB;
    end

    if (!rst_n) begin
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      pc_redirect = 1'b0;
      pc_target   = '0;
      fwd_a       = FWD_RF;
      fwd_b       = FWD_RF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_id) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (pc_redirect) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random traffic against a rule-level model.
module tb_hazard_ctrl;

  localparam int unsigned DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_id, uses_rs1, uses_rs2;
  logic [4:0]  rs1_id, rs2_id, rd_ex, rd_mem, rd_wb;
  logic        rf_enb1, is_Iload_typeb1, is_JALb1, is_JALRb1, is_mretb1, csr_wrb1, br_taken_ex;
  logic [31:0] target_ex;
  logic        rf_en_mem, rf_en_wb;
  logic        stall_if, stall_id, flush_if_id, flush_id_ex, pc_redirect;
  logic [31:0] pc_target;
  logic [1:0]  fwd_a, fwd_b;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: cycles of CSR drain still owed, plus perf tallies.
  int          drain_left = 0;
  int unsigned m_stalls   = 0;
  int unsigned m_flushes  = 0;
  logic        e_stall, e_redirect;

  always #5 clk = ~clk;

  hazard_ctrl #(.CSR_DRAIN_CYC(DRAIN), .XLEN_PC(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .rd_ex(rd_ex), .rf_enb1(rf_enb1),
    .is_Iload_typeb1(is_Iload_typeb1), .is_JALb1(is_JALb1), .is_JALRb1(is_JALRb1),
    .is_mretb1(is_mretb1), .csr_wrb1(csr_wrb1), .br_taken_ex(br_taken_ex),
    .target_ex(target_ex), .rd_mem(rd_mem), .rd_wb(rd_wb), .rf_en_mem(rf_en_mem),
    .rf_en_wb(rf_en_wb), .stall_if(stall_if), .stall_id(stall_id),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [1:0] fwd_of(input logic [4:0] rs);
    if (rf_en_mem && rd_mem != 0 && rd_mem == rs) return 2'd1;
    if (rf_en_wb && rd_wb != 0 && rd_wb == rs) return 2'd2;
    return 2'd0;
  endfunction

  task automatic check_all(input string ph);
    logic redir, lu, e_flush_ifid, e_flush_idex;
    logic [31:0] e_tgt;
    logic [1:0] e_fa, e_fb;
    redir = br_taken_ex | is_JALb1 | is_JALRb1 | is_mretb1;
    lu = valid_id && is_Iload_typeb1 && rf_enb1 && rd_ex != 0 &&
         ((uses_rs1 && rs1_id == rd_ex) || (uses_rs2 && rs2_id == rd_ex));
    e_stall = 0; e_redirect = 0; e_flush_ifid = 0; e_flush_idex = 0; e_tgt = 0;
    e_fa = fwd_of(rs1_id); e_fb = fwd_of(rs2_id);
    if (!rst_n) begin
      e_fa = 0; e_fb = 0;
    end else if (drain_left > 0) begin
      e_stall = 1; e_flush_idex = 1;
    end else if (redir) begin
      e_redirect = 1; e_tgt = target_ex; e_flush_ifid = 1; e_flush_idex = 1;
    end else if (lu) begin
      e_stall = 1; e_flush_idex = 1;
    end
    check({ph, ".stall_if"},    32'(stall_if),    32'(e_stall));
    check({ph, ".stall_id"},    32'(stall_id),    32'(e_stall));
    check({ph, ".flush_if_id"}, 32'(flush_if_id), 32'(e_flush_ifid));
    check({ph, ".flush_id_ex"}, 32'(flush_id_ex), 32'(e_flush_idex));
    check({ph, ".pc_redirect"}, 32'(pc_redirect), 32'(e_redirect));
    check({ph, ".pc_target"},   pc_target,        e_tgt);
    check({ph, ".fwd_a"},       32'(fwd_a),       32'(e_fa));
    check({ph, ".fwd_b"},       32'(fwd_b),       32'(e_fb));
`ifdef HAZARD_PERF_EN
    check({ph, ".stall_cycles"}, stall_cycles, m_stalls);
    check({ph, ".flush_count"},  flush_count,  m_flushes);
`endif
  endtask

  // Check the current cycle, advance the model across the coming rising edge, wait for next negedge.
  task automatic cycle(input string ph);
    #2;
    check_all(ph);
    if (!rst_n) begin
      drain_left = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (e_stall) m_stalls++;
      if (e_redirect) m_flushes++;
      if (drain_left > 0) drain_left--;
      else if (csr_wrb1 && !(br_taken_ex | is_JALb1 | is_JALRb1 | is_mretb1)) drain_left = DRAIN;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    valid_id = 0; uses_rs1 = 0; uses_rs2 = 0; rs1_id = 0; rs2_id = 0; rd_ex = 0;
    rf_enb1 = 0; is_Iload_typeb1 = 0; is_JALb1 = 0; is_JALRb1 = 0; is_mretb1 = 0;
    csr_wrb1 = 0; br_taken_ex = 0; target_ex = 0; rd_mem = 0; rd_wb = 0;
    rf_en_mem = 0; rf_en_wb = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    valid_id = 1; is_Iload_typeb1 = 1; rf_enb1 = 1; rd_ex = rd; uses_rs2 = 1; rs2_id = 5;
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    @(negedge clk);

    // Reset dominates redirect inputs.
    br_taken_ex = 1; is_JALb1 = 1; is_JALRb1 = 1; is_mretb1 = 1; target_ex = 32'h40;
    cycle("rst0");
    cycle("rst1");
    rst_n = 1;
    clear_inputs();
    cycle("idle");

    set_load_use(5'd5);
    cycle("lu");
    clear_inputs();
    cycle("lu_after");
    set_load_use(5'd0);
    cycle("lu_x0");
    clear_inputs();

    set_load_use(5'd5);
    br_taken_ex = 1; target_ex = 32'h0000_0040;
    cycle("br_over_lu");
    clear_inputs();
    is_JALRb1 = 1; target_ex = 32'h1234_5678;
    cycle("jalr");
    clear_inputs();

    csr_wrb1 = 1;
    cycle("csr_issue");
    csr_wrb1 = 0; br_taken_ex = 1; target_ex = 32'h80;
    cycle("drain1");
    br_taken_ex = 0;
    cycle("drain2");
    cycle("drain_done");

    rs1_id = 7; rd_mem = 7; rd_wb = 7; rf_en_mem = 1; rf_en_wb = 1;
    cycle("fwd_mem");
    rf_en_mem = 0;
    cycle("fwd_wb");
    rs1_id = 0; rd_mem = 0; rd_wb = 0;
    cycle("fwd_x0");
    clear_inputs();

    // Reset asserted mid-drain aborts it at once.
    csr_wrb1 = 1;
    cycle("csr2_issue");
    csr_wrb1 = 0;
    rst_n = 0;
    cycle("rst_mid_drain");
    rst_n = 1;
    cycle("post_rst");

    for (int i = 0; i < 600; i++) begin
      rst_n           = ($urandom_range(0, 99) != 0);
      valid_id        = 1'($urandom_range(0, 1));
      uses_rs1        = 1'($urandom_range(0, 1));
      uses_rs2        = 1'($urandom_range(0, 1));
      rs1_id          = 5'($urandom_range(0, 3));
      rs2_id          = 5'($urandom_range(0, 3));
      rd_ex           = 5'($urandom_range(0, 3));
      rd_mem          = 5'($urandom_range(0, 3));
      rd_wb           = 5'($urandom_range(0, 3));
      rf_enb1         = 1'($urandom_range(0, 1));
      rf_en_mem       = 1'($urandom_range(0, 1));
      rf_en_wb        = 1'($urandom_range(0, 1));
      is_Iload_typeb1 = 1'($urandom_range(0, 1));
      br_taken_ex     = ($urandom_range(0, 9) == 0);
      is_JALb1        = ($urandom_range(0, 19) == 0);
      is_JALRb1       = ($urandom_range(0, 19) == 0);
      is_mretb1       = ($urandom_range(0, 29) == 0);
      csr_wrb1        = ($urandom_range(0, 7) == 0);
      target_ex       = $urandom;
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
